// File: rtl/adder_sweep_ctrl_if.sv
// Operand/sum bus between the sweep controller and the adder pair it is testing.
//   a_op, b_op : operands, driven by the controller to both adders
//   s_ex       : sum from the exact adder (combinational from a_op/b_op)
//   s_ap       : sum from the approximate adder (combinational from a_op/b_op)
// Modports: master = controller side, slave = adder-pair side.
// No valid/ready handshake on this bus. The adders are purely combinational,
// so the controller samples s_ex/s_ap on the same rising edge that holds a_op/b_op.
interface adder_sweep_ctrl_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   s_ex;
  logic [WIDTH:0]   s_ap;

  modport master (output a_op, output b_op, input s_ex, input s_ap);
  modport slave  (input a_op, input b_op, output s_ex, output s_ap);
endinterface

// File: rtl/adder_sweep_ctrl.sv
// Exhaustive characterisation controller for an exact/approximate adder pair.
// On start it steps {a_op,b_op} through every 2*WIDTH-bit vector, one per cycle.
// For each vector it compares the two sums and accumulates these error statistics:
//   - mismatch count
//   - maximum and total error distance
//   - operands of the first mismatching vector
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : level; begins a sweep when sampled high in IDLE
//   bus         : master side of the operand/sum bus
//   busy        : high during the 2^(2*WIDTH) RUN cycles
//   done        : one-cycle pulse after the last vector
//   err_count, max_ed, sum_ed, first_valid, first_a, first_b : statistics
//   state_dbg   : current FSM state (0 IDLE, 1 RUN, 2 DONE)
module adder_sweep_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  adder_sweep_ctrl_if.master   bus,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH:0]     err_count,
  output logic [WIDTH:0]       max_ed,
  output logic [3*WIDTH:0]     sum_ed,
  output logic                 first_valid,
  output logic [WIDTH-1:0]     first_a,
  output logic [WIDTH-1:0]     first_b,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [2*WIDTH-1:0] VEC_ONE  = 1;
  localparam logic [2*WIDTH-1:0] VEC_LAST = '1;
  localparam logic [2*WIDTH:0]   ERR_ONE  = 1;

  state_t state, next_state;

  // {a_op,b_op} as one counter: b_op is the low half
  logic [2*WIDTH-1:0] vec, vec_d;
  logic               busy_d, done_d;
  logic [2*WIDTH:0]   err_d;
  logic [WIDTH:0]     max_d;
  logic [3*WIDTH:0]   sum_d;
  logic               fv_d;
  logic [WIDTH-1:0]   fa_d, fb_d;
  logic [WIDTH:0]     ed;

  assign bus.a_op  = vec[2*WIDTH-1:WIDTH];
  assign bus.b_op  = vec[WIDTH-1:0];
  assign state_dbg = state;

  // Both sums fit in WIDTH+1 bits, so ordering the subtraction gives an exact
  // absolute difference without needing a wider intermediate.
  assign ed = (bus.s_ex >= bus.s_ap) ? (bus.s_ex - bus.s_ap) : (bus.s_ap - bus.s_ex);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (vec == VEC_LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output / datapath next values. busy and done are registered from the
  // next state so they line up exactly with the RUN and DONE cycles.
  always_comb begin
    vec_d  = vec;
    busy_d = (next_state == RUN);
    done_d = (next_state == DONE);
    err_d  = err_count;
    max_d  = max_ed;
    sum_d  = sum_ed;
    fv_d   = first_valid;
    fa_d   = first_a;
    fb_d   = first_b;
    case (state)
      IDLE: begin
        vec_d = '0;
        if (start) begin
          err_d = '0;
          max_d = '0;
          sum_d = '0;
          fv_d  = 1'b0;
          fa_d  = '0;
          fb_d  = '0;
        end
      end
      RUN: begin
        // The last vector wraps the counter back to zero on its own.
        vec_d = vec + VEC_ONE;
        sum_d = sum_ed + {{(2*WIDTH){1'b0}}, ed};
        if (ed > max_ed) max_d = ed;
        if (ed != '0) begin
          err_d = err_count + ERR_ONE;
          if (!first_valid) begin
            fv_d = 1'b1;
            fa_d = bus.a_op;
            fb_d = bus.b_op;
          end
        end
      end
      default: vec_d = '0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_count   <= '0;
      max_ed      <= '0;
      sum_ed      <= '0;
      first_valid <= 1'b0;
      first_a     <= '0;
      first_b     <= '0;
    end else begin
      vec         <= vec_d;
      busy        <= busy_d;
      done        <= done_d;
      err_count   <= err_d;
      max_ed      <= max_d;
      sum_ed      <= sum_d;
      first_valid <= fv_d;
      first_a     <= fa_d;
      first_b     <= fb_d;
    end
  end

endmodule

// File: doc/adder_sweep_ctrl.md
ADDER_SWEEP_CTRL -- requirements
Module: adder_sweep_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, operand width of the exact/approximate adder pair under characterisation.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  level sampled each edge; starts an exhaustive sweep when in IDLE.
REQ-005 a_op  output  WIDTH  operand A driven to both adders.
REQ-006 b_op  output  WIDTH  operand B driven to both adders.
REQ-007 s_ex  input  WIDTH+1  sum from the exact adder (combinational from a_op/b_op).
REQ-008 s_ap  input  WIDTH+1  sum from the approximate adder (combinational from a_op/b_op).
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle pulse when a sweep completes.
REQ-011 err_count  output  2*WIDTH+1  number of vectors with s_ex != s_ap.
REQ-012 max_ed  output  WIDTH+1  largest error distance |s_ex - s_ap| seen.
REQ-013 sum_ed  output  3*WIDTH+1  sum of error distances over all vectors.
REQ-014 first_valid  output  1  high once a mismatch has been recorded in the current/last sweep.
REQ-015 first_a, first_b  output  WIDTH each  operands of the first mismatching vector.

Function
REQ-016 FSM states IDLE, RUN, DONE; all outputs registered.
REQ-017 IDLE: a_op=b_op=0, busy=0, done=0; statistics hold last sweep's values.
REQ-018 IDLE and start=1 at an edge -> RUN next cycle; same edge clears err_count, max_ed, sum_ed, first_valid, first_a, first_b to 0 and sets {a_op,b_op}=0.
REQ-019 start is ignored in RUN and DONE.
REQ-020 RUN: every edge samples s_ex/s_ap for current {a_op,b_op}, then increments the 2*WIDTH-bit vector counter {a_op,b_op} (b_op = low half, a_op = high half).
REQ-021 Per sample: ed = |s_ex - s_ap| computed unsigned on WIDTH+2 bits; ed != 0 -> err_count += 1; sum_ed += ed; max_ed = max(max_ed, ed).
REQ-022 First sample with ed != 0 while first_valid=0 -> first_a/first_b = current a_op/b_op, first_valid=1; later mismatches do not overwrite.
REQ-023 Sample of vector {a_op,b_op}=all-ones is the last; same edge -> DONE, {a_op,b_op} wraps to 0.
REQ-024 RUN lasts exactly 2^(2*WIDTH) cycles (256 for WIDTH=4); busy high for exactly those cycles.
REQ-025 DONE: done=1 for exactly one cycle, busy=0, then unconditionally IDLE; final statistics valid from the DONE cycle onward.
REQ-026 Accumulator widths suffice for full sweep; no saturation or overflow occurs.
REQ-027 Statistics update only on RUN samples; never in IDLE/DONE.

Reset
REQ-028 rst_n=0 forces, asynchronously: state=IDLE, a_op=b_op=0, busy=0, done=0, err_count=0, max_ed=0, sum_ed=0, first_valid=0, first_a=first_b=0.
REQ-029 Reset mid-RUN abandons the sweep; after release, block stays IDLE until a new start.

Verification (WIDTH=4)
REQ-030 s_ap tied to exact adder, start pulse -> busy high 256 cycles, done pulse next, err_count=0, max_ed=0, sum_ed=0, first_valid=0.
REQ-031 s_ap = exact sum with bit0 forced 0 -> err_count=128, max_ed=1, sum_ed=128, first_valid=1, first_a=0, first_b=1.
REQ-032 s_ap constant 0 -> err_count=255, max_ed=30, sum_ed=3840, first_a=0, first_b=1.
REQ-033 start held high through RUN and DONE -> still one sweep of 256 cycles; new sweep starts from next IDLE cycle with stats cleared.
REQ-034 rst_n low after 100 RUN cycles -> all outputs 0 immediately, IDLE after release, no done pulse.
REQ-035 Back-to-back sweeps, second with different approximate adder -> second-sweep stats independent of first.
